multicycle_ctrl: RTL
====================

# multicycle_ctrl

Parametrised multicycle MIPS control FSM; the next-generation main controller in the mini-MIPS datapath. It fetches an instruction over a configurable number of byte-wide memory beats, decodes the opcode, and sequences the datapath enables. It adds a memory-ready wait handshake, BNE, JAL and an illegal-opcode flag to the base LB/SB/R-type/BEQ/J/ADDI set.

## Interface
- FETCH_BEATS, 4, memory beats per instruction (legal 1..8); sets irwrite width and fetch length
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; clock clk
- op  in  6  instruction opcode (IR[31:26])
- zero  in  1  ALU zero flag
- memready  in  1  memory has completed the current read/write this cycle
- memread  out  1  memory read request (fetch beats, LBRD)
- memwrite  out  1  memory write strobe (SBWR)
- iord  out  1  1 = address from ALUOut, 0 = PC
- alusrca  out  1  1 = register A, 0 = PC
- alusrcb  out  2  00 B, 01 constant 1, 10 sign-ext imm, 11 branch offset
- aluop  out  2  00 add, 01 subtract, 10 use funct
- pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- pcen  out  1  PC load enable
- regwrite  out  1  register-file write
- regdst  out  2  00 rt, 01 rd, 10 r31
- wdsel  out  2  register write data: 00 ALUOut, 01 memory data, 10 PC
- irwrite  out  FETCH_BEATS  one-hot instruction-byte load enable
- illop  out  1  one-cycle pulse in DECODE on unsupported opcode

## Operation
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, BNE 000101, J 000010, JAL 000011, ADDI 001000.
- States: FETCH, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, BNEEX, JEX, JALEX, ADDIEX, ADDIWR.
- Fetch uses a beat counter, width ceil(log2(FETCH_BEATS)) (min 1), reset to 0.
- FETCH: memread=1, alusrcb=01. While memready=1: irwrite bit[beat]=1, pcwrite=1, beat increments. The last beat (beat==FETCH_BEATS-1) clears the counter and moves to DECODE. While memready=0: hold; irwrite=0, pcen=0.
- DECODE: alusrcb=11. Next state is by op: LB/SB→MEMADR, RTYPE→RTYPEEX, BEQ→BEQEX, BNE→BNEEX, J→JEX, JAL→JALEX, ADDI→ADDIEX. Any other op → FETCH with illop=1.
- MEMADR: alusrca=1, alusrcb=10; LB→LBRD, SB→SBWR.
- LBRD: memread=1, iord=1; hold until memready, then LBWR.
- LBWR: regwrite=1, wdsel=01, regdst=00.
- SBWR: memwrite=1, iord=1; hold until memready, then FETCH. memwrite stays asserted while waiting.
- RTYPEEX: alusrca=1, aluop=10. RTYPEWR: regwrite=1, regdst=01.
- ADDIEX: alusrca=1, alusrcb=10. ADDIWR: regwrite=1, regdst=00, wdsel=00.
- BEQEX / BNEEX: alusrca=1, aluop=01, pcsource=01; branch taken on zero / ~zero respectively.
- JEX: pcwrite=1, pcsource=10.
- JALEX: pcwrite=1, pcsource=10, regwrite=1, regdst=10, wdsel=10. Writes the pre-jump PC (already past the instruction) to r31 on the same edge the PC loads.
- pcen = pcwrite | (beqcond & zero) | (bnecond & ~zero).
- Every unlisted output is 0 in each state. Unreachable state encodings → FETCH, beat 0.

## Timing
- Outputs are combinational from state, beat, memready and zero. No output register.
- While reset=0, all outputs are forced to 0. On the first edge with reset=0, the FSM enters FETCH with beat 0.
- Reset mid-operation aborts the instruction at the next edge, including any pending SBWR write or partial fetch. No write strobe is asserted during reset.
- Zero-wait cycles per instruction (F = FETCH_BEATS): LB F+4, SB F+3, RTYPE/ADDI F+3, BEQ/BNE/J/JAL F+2, illegal F+1. Each memready=0 cycle in FETCH, LBRD or SBWR adds one cycle.
- memready is ignored outside FETCH, LBRD and SBWR.

## Test plan
- FETCH_BEATS=4, memready=1, ADDI → irwrite 0001,0010,0100,1000 on cycles 0-3, pcen=1 each; DECODE at cycle 4; regwrite=1, regdst=00 at cycle 6; FETCH at cycle 7.
- memready=0 for 3 cycles during beat 2 → irwrite=0, pcen=0 for 3 cycles, memread held; beat 2 loads with irwrite=0100 when memready rises; DECODE reached 3 cycles late.
- BEQ with zero=1 → pcen=1, pcsource=01 in BEQEX; BNE with zero=1 → pcen=0; BNE with zero=0 → pcen=1.
- JAL → single JALEX cycle with pcen=1, pcsource=10, regwrite=1, regdst=10, wdsel=10; then FETCH.
- op=111111 → illop=1 for exactly one cycle in DECODE, then FETCH beat 0; no regwrite or memwrite asserted.
- SB with memready low 2 cycles, reset=0 asserted on the 2nd wait cycle → memwrite drops that cycle; FETCH beat 0 after the edge. FETCH_BEATS=1 run: irwrite width 1, every fetch takes 1 cycle.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller drives the enables; the datapath returns opcode, ALU zero and memory ready.
interface multicycle_ctrl_if #(
  parameter int FETCH_BEATS = 4
);
  logic [5:0]             op;
  logic                   zero;
  logic                   memready;
  logic                   memread;
  logic                   memwrite;
  logic                   iord;
  logic                   alusrca;
  logic [1:0]             alusrcb;
  logic [1:0]             aluop;
  logic [1:0]             pcsource;
  logic                   pcen;
  logic                   regwrite;
  logic [1:0]             regdst;
  logic [1:0]             wdsel;
  logic [FETCH_BEATS-1:0] irwrite;
  logic                   illop;

  modport master (
    input  op, zero, memready,
    output memread, memwrite, iord, alusrca, alusrcb, aluop, pcsource,
           pcen, regwrite, regdst, wdsel, irwrite, illop
  );

  modport slave (
    output op, zero, memready,
    input  memread, memwrite, iord, alusrca, alusrcb, aluop, pcsource,
           pcen, regwrite, regdst, wdsel, irwrite, illop
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle mini-MIPS main controller: multi-beat byte fetch, decode and datapath sequencing,
// with memory-ready wait states on fetch, load and store. Outputs are combinational.
module multicycle_ctrl #(
  parameter int FETCH_BEATS = 4
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_ctrl_if.master bus
);

  localparam int BW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FETCH_BEATS - 1);

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_LBRD    = 4'd3,
    S_LBWR    = 4'd4,
    S_SBWR    = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWR = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_JEX     = 4'd10,
    S_JALEX   = 4'd11,
    S_ADDIEX  = 4'd12,
    S_ADDIWR  = 4'd13
  } state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;

  logic                   memread_s, memwrite_s, iord_s, alusrca_s;
  logic [1:0]             alusrcb_s, aluop_s, pcsource_s, regdst_s, wdsel_s;
  logic                   regwrite_s, illop_s;
  logic                   pcwrite_s, beqcond_s, bnecond_s, irload_s;
  logic [FETCH_BEATS-1:0] irwrite_s;

  // State and fetch-beat registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      beat_q  <= {BW{1'b0}};
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    iord_s     = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    aluop_s    = 2'b00;
    pcsource_s = 2'b00;
    regwrite_s = 1'b0;
    regdst_s   = 2'b00;
    wdsel_s    = 2'b00;
    illop_s    = 1'b0;
    pcwrite_s  = 1'b0;
    beqcond_s  = 1'b0;
    bnecond_s  = 1'b0;
    irload_s   = 1'b0;

    case (state_q)
      S_FETCH: begin
        memread_s = 1'b1;
        alusrcb_s = 2'b01;
        if (bus.memready) begin
          irload_s  = 1'b1;
          pcwrite_s = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = {BW{1'b0}};
            state_d = S_DECODE;
          end else begin
            beat_d  = beat_q + BW'(1'b1);
          end
        end else begin
          irload_s  = 1'b0;
        end
      end
      S_DECODE: begin
        alusrcb_s = 2'b11;
        case (bus.op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_J:         state_d = S_JEX;
          OP_JAL:       state_d = S_JALEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            illop_s = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        if (bus.op == OP_SB) begin
          state_d = S_SBWR;
        end else begin
          state_d = S_LBRD;
        end
      end
      S_LBRD: begin
        memread_s = 1'b1;
        iord_s    = 1'b1;
        if (bus.memready) begin
          state_d = S_LBWR;
        end else begin
          state_d = S_LBRD;
        end
      end
      S_LBWR: begin
        regwrite_s = 1'b1;
        wdsel_s    = 2'b01;
        state_d    = S_FETCH;
      end
      S_SBWR: begin
        // Strobe is held through wait cycles until memory acknowledges.
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
        if (bus.memready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_SBWR;
        end
      end
      S_RTYPEEX: begin
        alusrca_s = 1'b1;
        aluop_s   = 2'b10;
        state_d   = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regwrite_s = 1'b1;
        regdst_s   = 2'b01;
        state_d    = S_FETCH;
      end
      S_BEQEX: begin
        alusrca_s  = 1'b1;
        aluop_s    = 2'b01;
        pcsource_s = 2'b01;
        beqcond_s  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BNEEX: begin
        alusrca_s  = 1'b1;
        aluop_s    = 2'b01;
        pcsource_s = 2'b01;
        bnecond_s  = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcwrite_s  = 1'b1;
        pcsource_s = 2'b10;
        state_d    = S_FETCH;
      end
      S_JALEX: begin
        // PC already points past this instruction, so r31 takes the link value on the jump edge.
        pcwrite_s  = 1'b1;
        pcsource_s = 2'b10;
        regwrite_s = 1'b1;
        regdst_s   = 2'b10;
        wdsel_s    = 2'b10;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        state_d   = S_ADDIWR;
      end
      S_ADDIWR: begin
        regwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
        beat_d  = {BW{1'b0}};
      end
    endcase
  end

  // One-hot instruction-byte load enable for the current fetch beat.
  always_comb begin
    irwrite_s = {FETCH_BEATS{1'b0}};
    for (int i = 0; i < FETCH_BEATS; i++) begin
      irwrite_s[i] = irload_s & (beat_q == BW'(i));
    end
  end

  // Drive the bus; every output is held low while reset is asserted.
  always_comb begin
    bus.memread  = reset & memread_s;
    bus.memwrite = reset & memwrite_s;
    bus.iord     = reset & iord_s;
    bus.alusrca  = reset & alusrca_s;
    bus.alusrcb  = reset ? alusrcb_s  : 2'b00;
    bus.aluop    = reset ? aluop_s    : 2'b00;
    bus.pcsource = reset ? pcsource_s : 2'b00;
    bus.pcen     = reset & (pcwrite_s | (beqcond_s & bus.zero) | (bnecond_s & ~bus.zero));
    bus.regwrite = reset & regwrite_s;
    bus.regdst   = reset ? regdst_s   : 2'b00;
    bus.wdsel    = reset ? wdsel_s    : 2'b00;
    bus.irwrite  = reset ? irwrite_s  : {FETCH_BEATS{1'b0}};
    bus.illop    = reset & illop_s;
  end

endmodule
